// File: rtl/uart_word_rx.sv
// -----------------------------------------------------------------------------
// uart_word_rx
//   Receives 8N1 UART bytes on uart_rxd and packs them LSB-byte-first into
//   32-bit words, presented on a valid/ready output port and counted against a
//   word budget.
//
// Parameters
//   F_CLK, BAUD   : clock frequency and bit rate; CLKS_PER_BIT = F_CLK/BAUD
//   WORDS         : word count at which done_o sets (count saturates there)
//   TIMEOUT_BITS  : idle bit-times before a partial word is discarded
//
// Optional feature (compile-time macro UART_RX_TIMEOUT_EN)
//   Defined     : an idle counter drops a stale partial word and pulses
//                 timeout_o.
//   Not defined : partial words are kept indefinitely, timeout_o is tied 0.
//
// Ports
//   clk, rst      : system clock, asynchronous active-high reset
//   uart_rxd      : asynchronous serial input, idle high
//   clear_i       : one-cycle pulse; clears count, done, partial word, errors
//   word_o        : assembled word, byte k in bits [8k+7:8k]
//   word_valid_o  : word_o valid, held until accepted
//   word_ready_i  : consumer accept
//   word_cnt_o    : words loaded since reset/clear (saturating at WORDS)
//   done_o        : word_cnt_o == WORDS
//   frame_err_o   : sticky, a stop bit was sampled low
//   overrun_o     : sticky, a word completed while the output was still full
//   timeout_o     : one-cycle pulse when a partial word is discarded
//   dbg_state     : receiver FSM state (0 IDLE, 1 START, 2 DATA, 3 STOP)
//
// Handshake: a word transfers on every clock edge where word_valid_o and
// word_ready_i are both high. Once raised, word_valid_o and word_o stay
// stable until that transfer happens.
// -----------------------------------------------------------------------------
module uart_word_rx #(
  parameter int F_CLK        = 100000000,
  parameter int BAUD         = 115200,
  parameter int WORDS        = 1023,
  parameter int TIMEOUT_BITS = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        uart_rxd,
  input  logic        clear_i,
  output logic [31:0] word_o,
  output logic        word_valid_o,
  input  logic        word_ready_i,
  output logic [12:0] word_cnt_o,
  output logic        done_o,
  output logic        frame_err_o,
  output logic        overrun_o,
  output logic        timeout_o,
  output logic [1:0]  dbg_state
);

  localparam int CLKS_PER_BIT = F_CLK / BAUD;
  localparam int HALF_BIT     = CLKS_PER_BIT / 2;
  localparam int CNT_W        = $clog2(CLKS_PER_BIT + 1);

  localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(HALF_BIT - 1);
  localparam logic [12:0]      WORDS_C   = 13'(WORDS);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_START = 2'd1,
    S_DATA  = 2'd2,
    S_STOP  = 2'd3
  } state_t;

  state_t           state;
  logic             rxd_meta;
  logic             rxd_sync;
  logic [CNT_W-1:0] clk_cnt;
  logic [2:0]       bit_cnt;
  logic [7:0]       shreg;
  logic             byte_stb;
  logic             stop_bad;

  logic [1:0]       byte_idx;
  logic [23:0]      word_buf;
  logic             complete;
  logic             load;
  logic             accept;
  logic [12:0]      cnt_nxt;
  logic             timeout_hit;

  assign dbg_state = state;

  // Two-flop synchroniser; reset to the idle-high line level.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rxd_meta <= 1'b1;
      rxd_sync <= 1'b1;
    end else begin
      rxd_meta <= uart_rxd;
      rxd_sync <= rxd_meta;
    end
  end

  // Receiver FSM. byte_stb / stop_bad are registered one-cycle pulses issued
  // on the stop-bit sample.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= S_IDLE;
      clk_cnt  <= '0;
      bit_cnt  <= '0;
      shreg    <= '0;
      byte_stb <= 1'b0;
      stop_bad <= 1'b0;
    end else begin
      byte_stb <= 1'b0;
      stop_bad <= 1'b0;
      case (state)
        S_IDLE: begin
          if (!rxd_sync) begin
            state   <= S_START;
            clk_cnt <= '0;
          end
        end
        S_START: begin
          // Half a bit in: still low means a real start bit, else a glitch.
          if (clk_cnt == HALF_LAST) begin
            clk_cnt <= '0;
            bit_cnt <= '0;
            state   <= rxd_sync ? S_IDLE : S_DATA;
          end else begin
            clk_cnt <= clk_cnt + 1'b1;
          end
        end
        S_DATA: begin
          if (clk_cnt == BIT_LAST) begin
            clk_cnt <= '0;
            shreg   <= {rxd_sync, shreg[7:1]};
            bit_cnt <= bit_cnt + 1'b1;
            if (bit_cnt == 3'd7) state <= S_STOP;
          end else begin
            clk_cnt <= clk_cnt + 1'b1;
          end
        end
        S_STOP: begin
          if (clk_cnt == BIT_LAST) begin
            clk_cnt <= '0;
            state   <= S_IDLE;
            if (rxd_sync) byte_stb <= 1'b1;
            else          stop_bad <= 1'b1;
          end else begin
            clk_cnt <= clk_cnt + 1'b1;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  // Word assembly and output register.
  assign accept   = word_valid_o && word_ready_i;
  assign complete = byte_stb && (byte_idx == 2'd3);
  // A completed word loads into an empty register or one being drained now.
  assign load     = complete && (!word_valid_o || word_ready_i);

  always_comb begin
    cnt_nxt = word_cnt_o;
    if (clear_i)                             cnt_nxt = '0;
    else if (load && (word_cnt_o != WORDS_C)) cnt_nxt = word_cnt_o + 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      byte_idx     <= '0;
      word_buf     <= '0;
      word_o       <= '0;
      word_valid_o <= 1'b0;
      word_cnt_o   <= '0;
      done_o       <= 1'b0;
      frame_err_o  <= 1'b0;
      overrun_o    <= 1'b0;
    end else begin
      word_cnt_o <= cnt_nxt;
      done_o     <= (cnt_nxt == WORDS_C);

      if (load)        begin
        word_o       <= {shreg, word_buf};
        word_valid_o <= 1'b1;
      end else if (accept) begin
        word_valid_o <= 1'b0;
      end

      if (complete && !load) overrun_o <= 1'b1;

      if (byte_stb) begin
        case (byte_idx)
          2'd0:    word_buf[7:0]   <= shreg;
          2'd1:    word_buf[15:8]  <= shreg;
          2'd2:    word_buf[23:16] <= shreg;
          default: ;
        endcase
        byte_idx <= byte_idx + 1'b1;
      end

      if (stop_bad) begin
        frame_err_o <= 1'b1;
        byte_idx    <= '0;
      end

      if (timeout_hit) byte_idx <= '0;

      // Clear drops the partial word and errors; a word loading this cycle
      // still lands in the output register.
      if (clear_i) begin
        byte_idx    <= '0;
        frame_err_o <= 1'b0;
        overrun_o   <= 1'b0;
      end
    end
  end

`ifdef UART_RX_TIMEOUT_EN
  localparam int TO_LIMIT = TIMEOUT_BITS * CLKS_PER_BIT;
  localparam int TO_W     = $clog2(TO_LIMIT + 1);
  localparam logic [TO_W-1:0] TO_LAST = TO_W'(TO_LIMIT - 1);

  logic [TO_W-1:0] idle_cnt;
  logic            idle_counting;

  // Counts only while idle with a partial word; a start edge clears it.
  assign idle_counting = (state == S_IDLE) && (byte_idx != 2'd0) && rxd_sync;
  assign timeout_hit   = idle_counting && (idle_cnt == TO_LAST);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      idle_cnt  <= '0;
      timeout_o <= 1'b0;
    end else begin
      timeout_o <= timeout_hit;
      if (!idle_counting || timeout_hit) idle_cnt <= '0;
      else                               idle_cnt <= idle_cnt + 1'b1;
    end
  end
`else
  assign timeout_hit = 1'b0;
  assign timeout_o   = 1'b0;
`endif

endmodule

// File: tb/tb_uart_word_rx.sv
// -----------------------------------------------------------------------------
// tb_uart_word_rx
//   Bench for uart_word_rx at CLKS_PER_BIT = 16, WORDS = 3, TIMEOUT_BITS = 4.
//   Word results go through an expected queue checked on every accepted word;
//   status outputs are compared from a vector table and hand-written sequences.
// -----------------------------------------------------------------------------
module tb_uart_word_rx;

  localparam int CPB = 16;

  logic        clk = 1'b0;
  logic        rst;
  logic        uart_rxd;
  logic        clear_i;
  logic [31:0] word_o;
  logic        word_valid_o;
  logic        word_ready_i;
  logic [12:0] word_cnt_o;
  logic        done_o;
  logic        frame_err_o;
  logic        overrun_o;
  logic        timeout_o;
  logic [1:0]  dbg_state;

  always #5 clk = ~clk;

  uart_word_rx #(
    .F_CLK(16), .BAUD(1), .WORDS(3), .TIMEOUT_BITS(4)
  ) dut (
    .clk(clk), .rst(rst), .uart_rxd(uart_rxd), .clear_i(clear_i),
    .word_o(word_o), .word_valid_o(word_valid_o), .word_ready_i(word_ready_i),
    .word_cnt_o(word_cnt_o), .done_o(done_o), .frame_err_o(frame_err_o),
    .overrun_o(overrun_o), .timeout_o(timeout_o), .dbg_state(dbg_state)
  );

  int          n_checks  = 0;
  int          n_fail    = 0;
  int          to_pulses = 0;
  logic [31:0] exp_q[$];
  logic [31:0] mon_exp;
  logic [31:0] tmo_word;

  typedef struct {
    logic [7:0]  b0, b1, b2, b3;
    logic [31:0] exp_word;
    logic [12:0] exp_cnt;
    logic        exp_done;
  } vec_t;
  vec_t vecs[4];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Scoreboard: every accepted word must match the head of the queue.
  always @(negedge clk) begin
    if (!rst) begin
      if (timeout_o) to_pulses++;
      if (word_valid_o && word_ready_i) begin
        if (exp_q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL unexpected_word: got %h expected none", word_o);
        end else begin
          mon_exp = exp_q.pop_front();
          chk("word_out", word_o, mon_exp);
        end
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic send_byte(input logic [7:0] b, input logic stop_ok);
    uart_rxd = 1'b0;
    tick(CPB);
    for (int i = 0; i < 8; i++) begin
      uart_rxd = b[i];
      tick(CPB);
    end
    uart_rxd = stop_ok;
    tick(CPB);
    uart_rxd = 1'b1;
    tick(4);
  endtask

  task automatic send_word(input logic [31:0] w);
    for (int k = 0; k < 4; k++) send_byte(w[8*k +: 8], 1'b1);
  endtask

  task automatic pulse_clear();
    clear_i = 1'b1;
    tick(1);
    clear_i = 1'b0;
    tick(1);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected test end");
    $fatal(1, "watchdog expired");
  end

  initial begin
    vecs[0] = '{8'hEF, 8'hBE, 8'hAD, 8'hDE, 32'hDEADBEEF, 13'd1, 1'b0};
    vecs[1] = '{8'h78, 8'h56, 8'h34, 8'h12, 32'h12345678, 13'd2, 1'b0};
    vecs[2] = '{8'h00, 8'hFF, 8'h0F, 8'hA5, 32'hA50FFF00, 13'd3, 1'b1};
    vecs[3] = '{8'h5A, 8'hC3, 8'h01, 8'h80, 32'h8001C35A, 13'd3, 1'b1};

    rst          = 1'b1;
    uart_rxd     = 1'b1;
    clear_i      = 1'b0;
    word_ready_i = 1'b1;
    tick(5);
    rst = 1'b0;
    tick(3);

    chk("rst_word",      word_o,                32'h0);
    chk("rst_valid",     32'(word_valid_o),     32'h0);
    chk("rst_cnt",       32'(word_cnt_o),       32'h0);
    chk("rst_done",      32'(done_o),           32'h0);
    chk("rst_frame_err", 32'(frame_err_o),      32'h0);
    chk("rst_overrun",   32'(overrun_o),        32'h0);
    chk("rst_timeout",   32'(timeout_o),        32'h0);
    chk("rst_state",     32'(dbg_state),        32'h0);

    // Table: words with ready high; count saturates at 3.
    for (int v = 0; v < 4; v++) begin
      exp_q.push_back(vecs[v].exp_word);
      send_byte(vecs[v].b0, 1'b1);
      send_byte(vecs[v].b1, 1'b1);
      send_byte(vecs[v].b2, 1'b1);
      send_byte(vecs[v].b3, 1'b1);
      chk("tbl_cnt",     32'(word_cnt_o),   32'(vecs[v].exp_cnt));
      chk("tbl_done",    32'(done_o),       32'(vecs[v].exp_done));
      chk("tbl_drained", 32'(exp_q.size()), 32'd0);
      chk("tbl_valid",   32'(word_valid_o), 32'd0);
    end
    pulse_clear();
    chk("clr_cnt",  32'(word_cnt_o), 32'd0);
    chk("clr_done", 32'(done_o),     32'd0);

    // Overrun: first word held, second dropped.
    word_ready_i = 1'b0;
    exp_q.push_back(32'h11223344);
    send_word(32'h11223344);
    chk("ovr_valid1",   32'(word_valid_o), 32'd1);
    chk("ovr_word1",    word_o,            32'h11223344);
    chk("ovr_flag0",    32'(overrun_o),    32'd0);
    send_word(32'hCAFEF00D);
    chk("ovr_held",     word_o,            32'h11223344);
    chk("ovr_valid2",   32'(word_valid_o), 32'd1);
    chk("ovr_flag1",    32'(overrun_o),    32'd1);
    chk("ovr_cnt",      32'(word_cnt_o),   32'd1);
    word_ready_i = 1'b1;
    tick(1);
    chk("ovr_drop_valid", 32'(word_valid_o), 32'd0);
    chk("ovr_drained",    32'(exp_q.size()), 32'd0);
    pulse_clear();
    chk("ovr_clr", 32'(overrun_o), 32'd0);

    // Framing error drops the partial word.
    send_byte(8'h11, 1'b1);
    send_byte(8'h55, 1'b0);
    chk("ferr_flag", 32'(frame_err_o), 32'd1);
    exp_q.push_back(32'h11223344);
    send_word(32'h11223344);
    chk("ferr_drained", 32'(exp_q.size()), 32'd0);
    chk("ferr_cnt",     32'(word_cnt_o),   32'd1);
    pulse_clear();
    chk("ferr_clr", 32'(frame_err_o), 32'd0);

    // Short low glitch: START entered, then back to IDLE with nothing received.
    uart_rxd = 1'b0;
    tick(4);
    chk("gl_start", 32'(dbg_state), 32'd1);
    tick(2);
    uart_rxd = 1'b1;
    tick(14);
    chk("gl_idle", 32'(dbg_state),   32'd0);
    chk("gl_ferr", 32'(frame_err_o), 32'd0);
    exp_q.push_back(32'hA1B2C3D4);
    send_word(32'hA1B2C3D4);
    chk("gl_drained", 32'(exp_q.size()), 32'd0);
    chk("gl_cnt",     32'(word_cnt_o),   32'd1);

    // Reset mid-byte with a held word and a partial word outstanding.
    word_ready_i = 1'b0;
    send_word(32'h0BADF00D);
    send_byte(8'h77, 1'b1);
    uart_rxd = 1'b0;
    tick(CPB * 3);
    rst = 1'b1;
    tick(2);
    chk("mr_word",  word_o,            32'h0);
    chk("mr_valid", 32'(word_valid_o), 32'd0);
    chk("mr_cnt",   32'(word_cnt_o),   32'd0);
    chk("mr_state", 32'(dbg_state),    32'd0);
    chk("mr_done",  32'(done_o),       32'd0);
    uart_rxd = 1'b1;
    tick(2);
    rst = 1'b0;
    word_ready_i = 1'b1;
    tick(4);
    exp_q.push_back(32'h89ABCDEF);
    send_word(32'h89ABCDEF);
    chk("mr_drained", 32'(exp_q.size()), 32'd0);
    chk("mr_cnt2",    32'(word_cnt_o),   32'd1);

    // Idle timeout on a partial word.
    pulse_clear();
    to_pulses = 0;
    send_byte(8'hAA, 1'b1);
    send_byte(8'hBB, 1'b1);
    tick(80);
`ifdef UART_RX_TIMEOUT_EN
    chk("to_pulses", 32'(to_pulses), 32'd1);
    tmo_word = 32'h04030201;
`else
    chk("to_pulses", 32'(to_pulses), 32'd0);
    tmo_word = 32'h0201BBAA;
`endif
    exp_q.push_back(tmo_word);
    send_word(32'h04030201);
    tick(CPB * 12);
    chk("to_drained", 32'(exp_q.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
